// File: rtl/tsn_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tsn_timer_pkg
// Brief    : Shared defaults, correction FSM state and helpers for the
//            picoTSN local time base.
// Revision : 1.0
// ============================================================================
package tsn_timer_pkg;

    localparam int c_DEF_TIME_W       = 32;
    localparam int c_DEF_N_PORTS      = 4;
    localparam int c_DEF_SYNC_BITS    = 16;
    localparam int c_DEF_DEB_LEN      = 16;
    localparam int c_DEF_SLEW_THRESH  = 8;
    localparam int c_DEF_LOCK_THRESH  = 4;
    localparam int c_DEF_LOCK_CNT     = 8;
    localparam int c_DEF_REPORT_EVERY = 190;
    localparam int c_DEF_OUT_W        = 12;

    // Offsets are sign-extended to this width so that the magnitude of the
    // most negative TIME_W value is still representable.
    localparam int c_ABS_W = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SLEW = 1'b1
    } state_t;

    function automatic logic [c_ABS_W-1:0] abs_signed(input logic [c_ABS_W-1:0] v);
        return v[c_ABS_W-1] ? (~v + c_ABS_W'(1)) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Brief    : Shift-register debouncer; accepts a level after DEB_LEN equal
//            samples and flags each change of the accepted level.
// Revision : 1.0
// ============================================================================
module sync_debounce
    import tsn_timer_pkg::*;
#(
    parameter int DEB_LEN = c_DEF_DEB_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic edge_det
);

    logic [DEB_LEN-1:0] r_shift;
    logic               r_level_d;

    // The first shift stage doubles as the sampling flop for asynchronous
    // inputs; a metastable sample can only delay acceptance by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            level     <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_shift   <= {r_shift[DEB_LEN-2:0], raw};
            r_level_d <= level;
            if (&r_shift) begin
                level <= 1'b1;
            end else if (~|r_shift) begin
                level <= 1'b0;
            end
        end
    end

    assign edge_det = level ^ r_level_d;

endmodule
`default_nettype wire

// File: rtl/tsn_sync_timer.sv
`default_nettype none
// ============================================================================
// Module   : tsn_sync_timer
// Brief    : Local time base with four-timestamp offset correction (step or
//            slew), lock detection, sync output and phase reporting.
// Revision : 1.0
// ============================================================================
module tsn_sync_timer
    import tsn_timer_pkg::*;
#(
    parameter int TIME_W       = c_DEF_TIME_W,
    parameter int N_PORTS      = c_DEF_N_PORTS,
    parameter int SYNC_BITS    = c_DEF_SYNC_BITS,
    parameter int DEB_LEN      = c_DEF_DEB_LEN,
    parameter int SLEW_THRESH  = c_DEF_SLEW_THRESH,
    parameter int LOCK_THRESH  = c_DEF_LOCK_THRESH,
    parameter int LOCK_CNT     = c_DEF_LOCK_CNT,
    parameter int REPORT_EVERY = c_DEF_REPORT_EVERY,
    parameter int OUT_W        = c_DEF_OUT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          update_time_valid,
    input  logic [N_PORTS*4*TIME_W-1:0] update_time,
    output logic [TIME_W-1:0]           local_time,
    input  logic                        time_int_i,
    output logic                        time_int_o,
    output logic                        offset_time_valid_o,
    output logic [OUT_W-1:0]            offset_time_o,
    output logic                        adj_busy,
    output logic [TIME_W-1:0]           last_offset,
    output logic                        locked
);

    localparam int c_LC_W  = $clog2(LOCK_CNT + 1);
    localparam int c_EC_W  = $clog2(REPORT_EVERY + 1);
    localparam int c_RES_W = $clog2(SLEW_THRESH + 1);

    localparam logic [TIME_W-1:0]  c_ONE     = TIME_W'(1);
    localparam logic [TIME_W-1:0]  c_TWO     = TIME_W'(2);
    localparam logic [c_LC_W-1:0]  c_LC_MAX  = c_LC_W'(LOCK_CNT);
    localparam logic [c_EC_W-1:0]  c_EC_LAST = c_EC_W'(REPORT_EVERY - 1);
    localparam logic [c_RES_W-1:0] c_RES_ONE = c_RES_W'(1);

    logic [TIME_W-1:0] w_off [N_PORTS];
    logic              w_v3  [N_PORTS];

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [TIME_W-1:0] w_t0, w_t1, w_t2, w_t3;
        logic [TIME_W-1:0] r_a, r_b, r_s, r_off;
        logic              r_v1, r_v2, r_v3;

        assign {w_t0, w_t1, w_t2, w_t3} = update_time[p*4*TIME_W +: 4*TIME_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a   <= '0;
                r_b   <= '0;
                r_s   <= '0;
                r_off <= '0;
                r_v1  <= 1'b0;
                r_v2  <= 1'b0;
                r_v3  <= 1'b0;
            end else begin
                r_a   <= w_t0 - w_t1;
                r_b   <= w_t3 - w_t2;
                r_v1  <= update_time_valid[p];
                r_s   <= r_a + r_b;
                r_v2  <= r_v1;
                r_off <= $signed(r_s) >>> 1;
                r_v3  <= r_v2;
            end
        end

        assign w_off[p] = r_off;
        assign w_v3[p]  = r_v3;
    end

    logic               w_sel_v;
    logic [TIME_W-1:0]  w_sel_off;
    logic [c_ABS_W-1:0] w_abs;
    logic               w_big;
    logic               w_inlock;
    logic [c_LC_W-1:0]  w_lock_nxt;

    state_t             r_state;
    logic [c_RES_W-1:0] r_residual;
    logic               r_dir_neg;
    logic [c_LC_W-1:0]  r_lock_cnt;

    // Later ports overwrite earlier ones, so the highest valid index wins.
    always_comb begin
        w_sel_v   = 1'b0;
        w_sel_off = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (w_v3[p]) begin
                w_sel_v   = 1'b1;
                w_sel_off = w_off[p];
            end
        end
        w_abs    = abs_signed({{(c_ABS_W-TIME_W){w_sel_off[TIME_W-1]}}, w_sel_off});
        w_big    = w_abs > c_ABS_W'(SLEW_THRESH);
        w_inlock = w_abs <= c_ABS_W'(LOCK_THRESH);

        w_lock_nxt = r_lock_cnt;
        if (w_sel_v) begin
            if (!w_inlock) begin
                w_lock_nxt = '0;
            end else if (r_lock_cnt != c_LC_MAX) begin
                w_lock_nxt = r_lock_cnt + c_LC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            local_time  <= '0;
            r_state     <= IDLE;
            r_residual  <= '0;
            r_dir_neg   <= 1'b0;
            adj_busy    <= 1'b0;
            last_offset <= '0;
            r_lock_cnt  <= '0;
            locked      <= 1'b0;
        end else begin
            local_time <= local_time + c_ONE;
            r_lock_cnt <= w_lock_nxt;
            locked     <= (w_lock_nxt == c_LC_MAX);
            if (w_sel_v) begin
                last_offset <= w_sel_off;
                if (w_big) begin
                    local_time <= local_time + c_ONE + w_sel_off;
                    r_state    <= IDLE;
                    r_residual <= '0;
                    adj_busy   <= 1'b0;
                end else if (w_abs == '0) begin
                    r_state    <= IDLE;
                    r_residual <= '0;
                    adj_busy   <= 1'b0;
                end else begin
                    r_state    <= SLEW;
                    r_residual <= w_abs[c_RES_W-1:0];
                    r_dir_neg  <= w_sel_off[TIME_W-1];
                    adj_busy   <= 1'b1;
                end
            end else if (r_state == SLEW) begin
                local_time <= r_dir_neg ? local_time : local_time + c_TWO;
                r_residual <= r_residual - c_RES_ONE;
                if (r_residual == c_RES_ONE) begin
                    r_state  <= IDLE;
                    adj_busy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_int_o <= 1'b0;
        end else begin
            time_int_o <= local_time[SYNC_BITS];
        end
    end

    logic w_lvl_in, w_edge_in, w_lvl_out, w_edge_out;

    sync_debounce #(.DEB_LEN(DEB_LEN)) u_deb_in (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (time_int_i),
        .level    (w_lvl_in),
        .edge_det (w_edge_in)
    );

    sync_debounce #(.DEB_LEN(DEB_LEN)) u_deb_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (time_int_o),
        .level    (w_lvl_out),
        .edge_det (w_edge_out)
    );

    logic                 w_any_edge;
    logic [OUT_W-1:0]     w_phase;
    logic [SYNC_BITS-1:0] r_cnt;
    logic [c_EC_W-1:0]    r_edge_cnt;

    assign w_any_edge = w_edge_in | w_edge_out;
    // Past half a sync period the distance is measured from the other side.
    assign w_phase    = r_cnt[SYNC_BITS-1] ? ~r_cnt[OUT_W-1:0] : r_cnt[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt               <= '0;
            r_edge_cnt          <= '0;
            offset_time_valid_o <= 1'b0;
            offset_time_o       <= '0;
        end else begin
            r_cnt               <= r_cnt + SYNC_BITS'(1);
            offset_time_valid_o <= 1'b0;
            if (w_any_edge) begin
                r_cnt <= '0;
                if (r_edge_cnt == c_EC_LAST) begin
                    offset_time_valid_o <= 1'b1;
                    offset_time_o       <= w_phase;
                    r_edge_cnt          <= '0;
                end else begin
                    r_edge_cnt <= r_edge_cnt + c_EC_W'(1);
                end
            end
            if (|update_time_valid) begin
                r_edge_cnt <= c_EC_LAST;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tsn_sync_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tsn_sync_timer
// Brief    : Directed, table-driven bench for the picoTSN local time base.
// Revision : 1.0
// ============================================================================
module tb_tsn_sync_timer;

    localparam int TW = 32;
    localparam int NP = 4;
    localparam int OW = 12;
    localparam int NV = 14;

    typedef struct {
        int            port;
        logic [TW-1:0] t0, t1, t2, t3;
        logic [TW-1:0] off;
        logic          lck;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NP-1:0]      update_time_valid = '0;
    logic [NP*4*TW-1:0] update_time = '0;
    logic [TW-1:0]      local_time;
    logic               time_int_i = 1'b0;
    logic               time_int_o;
    logic               offset_time_valid_o;
    logic [OW-1:0]      offset_time_o;
    logic               adj_busy;
    logic [TW-1:0]      last_offset;
    logic               locked;

    tsn_sync_timer u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .update_time_valid   (update_time_valid),
        .update_time         (update_time),
        .local_time          (local_time),
        .time_int_i          (time_int_i),
        .time_int_o          (time_int_o),
        .offset_time_valid_o (offset_time_valid_o),
        .offset_time_o       (offset_time_o),
        .adj_busy            (adj_busy),
        .last_offset         (last_offset),
        .locked              (locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vec_t          tbl [NV];
    logic [TW-1:0] l0, dl, off_v;
    int            busy_n, hold_n, strobes, wait_n, t_last;
    logic [TW-1:0] prev;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                            input logic [TW-1:0] t2, input logic [TW-1:0] t3);
        update_time[p*4*TW +: 4*TW] = {t0, t1, t2, t3};
    endtask

    task automatic pulse(input logic [NP-1:0] m);
        update_time_valid = m;
        tick();
        update_time_valid = '0;
    endtask

    task automatic wait_strobe(input string name, input logic [OW-1:0] exp);
        int k = 0;
        while (!offset_time_valid_o && k < 80) begin
            tick();
            k++;
        end
        if (!offset_time_valid_o) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check(name, 64'(offset_time_o), 64'(exp));
        end
    endtask

    function automatic logic [OW-1:0] exp_phase(input int d);
        logic [15:0] c;
        c = 16'(d - 1);
        return c[15] ? ~c[OW-1:0] : c[OW-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no $finish, expected one within 100k cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 32'd100, 32'd80, 32'd200, 32'd210, 32'd15, 1'b0};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{i % 4, 32'd12, 32'd10, 32'd5, 32'd7, 32'd2, (i == 8)};
        end
        tbl[9]  = '{2, 32'd40, 32'd15, 32'd100, 32'd115, 32'd20, 1'b0};
        tbl[10] = '{1, 32'd0, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0};
        tbl[11] = '{3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        tbl[12] = '{0, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF3, 1'b0};
        tbl[13] = '{2, 32'd50, 32'd250, 32'd0, 32'd0, 32'hFFFF_FF9C, 1'b0};

        // Reset state
        repeat (3) tick();
        check("rst_local_time", 64'(local_time), 64'd0);
        check("rst_time_int_o", 64'(time_int_o), 64'd0);
        check("rst_valid", 64'(offset_time_valid_o), 64'd0);
        check("rst_offset_time", 64'(offset_time_o), 64'd0);
        check("rst_adj_busy", 64'(adj_busy), 64'd0);
        check("rst_last_offset", 64'(last_offset), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        rst_n = 1'b1;

        // Exact step latency from local_time = 1000
        wait_n = 0;
        while (local_time != 32'd1000 && wait_n < 1200) begin
            tick();
            wait_n++;
        end
        check("wait_lt_1000", 64'(local_time), 64'd1000);
        set_port(0, 32'd100, 32'd80, 32'd200, 32'd210);
        pulse(4'b0001);
        repeat (3) tick();
        check("step_local_time", 64'(local_time), 64'd1019);
        check("step_last_offset", 64'(last_offset), 64'd15);
        check("step_adj_busy", 64'(adj_busy), 64'd0);

        // Positive slew, off = 5
        set_port(1, 32'd16, 32'd10, 32'd0, 32'd4);
        l0 = local_time;
        pulse(4'b0010);
        busy_n = 0;
        for (int i = 0; i < 11; i++) begin
            if (adj_busy) busy_n++;
            tick();
        end
        dl = local_time - l0;
        check("slewp_busy_cycles", 64'(busy_n), 64'd5);
        check("slewp_delta", 64'(dl), 64'd17);

        // Negative slew, off = -3
        set_port(2, 32'd0, 32'd6, 32'd0, 32'd0);
        l0 = local_time;
        pulse(4'b0100);
        busy_n = 0;
        hold_n = 0;
        prev = local_time;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (adj_busy) busy_n++;
            if (local_time == prev) hold_n++;
            prev = local_time;
        end
        dl = local_time - l0;
        check("slewn_busy_cycles", 64'(busy_n), 64'd3);
        check("slewn_hold_cycles", 64'(hold_n), 64'd3);
        check("slewn_delta", 64'(dl), 64'd9);
        check("slewn_last_offset", 64'(last_offset), 64'hFFFF_FFFD);

        // Asynchronous reset mid-slew
        set_port(0, 32'd16, 32'd10, 32'd0, 32'd4);
        pulse(4'b0001);
        repeat (4) tick();
        check("midslew_busy", 64'(adj_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midslew_rst_busy", 64'(adj_busy), 64'd0);
        check("midslew_rst_lt", 64'(local_time), 64'd0);
        check("midslew_rst_last", 64'(last_offset), 64'd0);
        tick();
        rst_n = 1'b1;

        // Asynchronous reset mid-pipeline discards the pending offset
        pulse(4'b0001);
        tick();
        #2 rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (adj_busy) busy_n++;
        end
        check("midpipe_busy", 64'(busy_n), 64'd0);
        check("midpipe_last", 64'(last_offset), 64'd0);

        // Table: steps, slews, rounding, wrap arithmetic and lock
        for (int i = 0; i < NV; i++) begin
            set_port(tbl[i].port, tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].t3);
            l0 = local_time;
            pulse(4'b0001 << tbl[i].port);
            repeat (7) tick();
            dl = local_time - l0;
            off_v = 32'd8 + tbl[i].off;
            check($sformatf("tbl%0d_delta", i), 64'(dl), 64'(off_v));
            check($sformatf("tbl%0d_last", i), 64'(last_offset), 64'(tbl[i].off));
            check($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].lck));
        end

        // Port priority: port 1 (+100) and port 3 (-50) together
        set_port(1, 32'd200, 32'd0, 32'd0, 32'd0);
        set_port(3, 32'd0, 32'd100, 32'd0, 32'd0);
        l0 = local_time;
        pulse(4'b1010);
        repeat (7) tick();
        dl = local_time - l0;
        check("prio_delta", 64'(dl), 64'(32'hFFFF_FFD6));
        check("prio_last", 64'(last_offset), 64'(32'hFFFF_FFCE));

        // Step to 50 counts below the first sync boundary
        l0 = local_time;
        off_v = 32'd65486 - (l0 + 32'd4);
        set_port(0, off_v << 1, 32'd0, 32'd0, 32'd0);
        pulse(4'b0001);
        repeat (3) tick();
        check("presync_lt", 64'(local_time), 64'd65486);
        check("presync_time_int_o", 64'(time_int_o), 64'd0);
        wait_n = 0;
        while (!time_int_o && wait_n < 100) begin
            tick();
            wait_n++;
        end
        check("sync_rise", 64'(time_int_o), 64'd1);
        check("sync_rise_cycle", 64'(wait_n), 64'd51);

        // Arm report, glitch (ignored), then clean toggle 300 cycles later
        set_port(0, 32'd0, 32'd0, 32'd0, 32'd0);
        strobes = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c > 100 && offset_time_valid_o) strobes++;
            update_time_valid = (c == 100) ? 4'b0001 : 4'b0000;
            if (c == 150) time_int_i = 1'b1;
            else if (c == 151 || c < 150) time_int_i = 1'b0;
            if (c == 300) time_int_i = 1'b1;
        end
        check("glitch_no_report", 64'(strobes), 64'd0);
        wait_strobe("phase_299", exp_phase(300));

        // Next report exactly 190 edges later
        strobes = 0;
        for (int n = 1; n <= 190; n++) begin
            for (int c = 0; c < 40; c++) begin
                tick();
                if (offset_time_valid_o) strobes++;
            end
            time_int_i = ~time_int_i;
        end
        t_last = cyc;
        check("no_early_report", 64'(strobes), 64'd0);
        wait_strobe("report_190", exp_phase(40));

        // cnt beyond half period reports the complemented distance
        pulse(4'b0001);
        while (cyc - t_last < 33000) tick();
        time_int_i = ~time_int_i;
        wait_strobe("phase_wrap", exp_phase(33000));
        check("phase_wrap_const", 64'(offset_time_o), 64'h0F18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
